// File: rtl/adf5610_spi_seq.sv
// adf5610_spi_seq: programs an ADF5610 word through an Avalon SPI master, holding SS via SSO.
// Define ADF5610_SEQ_READBACK_EN to capture MISO bytes into rsp_data and flag ROE in err.
module adf5610_spi_seq #(
  parameter int unsigned WORD_BYTES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rsp_data,
  output logic        spi_select,
  output logic [2:0]  spi_addr,
  output logic [15:0] spi_wdata,
  output logic        spi_read_n,
  output logic        spi_write_n,
  input  logic [15:0] spi_rdata
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, CLR_STAT, SET_SS, SET_SSO, POLL_TRDY, WR_TX,
    POLL_RRDY, RD_RX, POLL_TMT, REL_SSO, DONE
  } state_t;

  state_t        state, state_next;
  logic [1:0]    phase, phase_next;
  logic [TW-1:0] tcnt;
  logic [1:0]    bcnt, bcnt_next;
  logic [31:0]   word;
  logic          err_q, err_next;
  logic          accept;
  logic          last, poll_to;
  logic          op_wr, op_rd;
  logic [2:0]    op_addr;
  logic [15:0]   op_wdata;
  logic          unused_rdata;

`ifdef ADF5610_SEQ_READBACK_EN
  logic [31:0]   acc, acc_next;
`endif

  assign accept       = (state == IDLE) && cmd_valid;
  assign last         = (phase == 2'd2);
  assign poll_to      = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign unused_rdata = ^spi_rdata;

  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    err_next   = err_q;
    op_wr      = 1'b0;
    op_rd      = 1'b0;
    op_addr    = '0;
    op_wdata   = '0;
`ifdef ADF5610_SEQ_READBACK_EN
    acc_next   = acc;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = CLR_STAT;
          bcnt_next  = 2'(WORD_BYTES - 1);
          err_next   = 1'b0;
`ifdef ADF5610_SEQ_READBACK_EN
          acc_next   = '0;
`endif
        end
      end
      CLR_STAT: begin
        op_wr   = 1'b1;
        op_addr = 3'd2;
        if (last) state_next = SET_SS;
      end
      SET_SS: begin
        op_wr    = 1'b1;
        op_addr  = 3'd5;
        op_wdata = 16'h0001;
        if (last) state_next = SET_SSO;
      end
      SET_SSO: begin
        op_wr    = 1'b1;
        op_addr  = 3'd3;
        op_wdata = 16'h0400;
        if (last) state_next = POLL_TRDY;
      end
      POLL_TRDY: begin
        op_rd   = 1'b1;
        op_addr = 3'd2;
        if (last && spi_rdata[6]) state_next = WR_TX;
        else if (poll_to) begin
          err_next   = 1'b1;
          state_next = REL_SSO;
        end
      end
      WR_TX: begin
        op_wr    = 1'b1;
        op_addr  = 3'd1;
        op_wdata = {8'h00, word[{bcnt, 3'b000} +: 8]};
        if (last) begin
`ifdef ADF5610_SEQ_READBACK_EN
          state_next = POLL_RRDY;
`else
          if (bcnt != 2'd0) begin
            bcnt_next  = bcnt - 2'd1;
            state_next = POLL_TRDY;
          end else begin
            state_next = POLL_TMT;
          end
`endif
        end
      end
`ifdef ADF5610_SEQ_READBACK_EN
      POLL_RRDY: begin
        op_rd   = 1'b1;
        op_addr = 3'd2;
        if (last && spi_rdata[7]) state_next = RD_RX;
        else if (poll_to) begin
          err_next   = 1'b1;
          state_next = REL_SSO;
        end
      end
      RD_RX: begin
        op_rd   = 1'b1;
        op_addr = 3'd0;
        if (last) begin
          acc_next = {acc[23:0], spi_rdata[7:0]};
          if (bcnt != 2'd0) begin
            bcnt_next  = bcnt - 2'd1;
            state_next = POLL_TRDY;
          end else begin
            state_next = POLL_TMT;
          end
        end
      end
`endif
      POLL_TMT: begin
        op_rd   = 1'b1;
        op_addr = 3'd2;
        if (last && spi_rdata[5]) begin
`ifdef ADF5610_SEQ_READBACK_EN
          err_next = err_q | spi_rdata[3];
`endif
          state_next = REL_SSO;
        end else if (poll_to) begin
          err_next   = 1'b1;
          state_next = REL_SSO;
        end
      end
      REL_SSO: begin
        op_wr   = 1'b1;
        op_addr = 3'd3;
        if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // a failed poll wraps phase back to 0 and re-reads within the same state
    phase_next = phase;
    if (state_next != state)  phase_next = '0;
    else if (op_wr || op_rd)  phase_next = last ? 2'd0 : phase + 2'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      phase <= '0;
      tcnt  <= '0;
      bcnt  <= '0;
      word  <= '0;
      err_q <= 1'b0;
`ifdef ADF5610_SEQ_READBACK_EN
      acc   <= '0;
`endif
    end else begin
      state <= state_next;
      phase <= phase_next;
      tcnt  <= (state_next != state) ? '0 : tcnt + 1'b1;
      bcnt  <= bcnt_next;
      err_q <= err_next;
      if (accept) word <= cmd_data;
`ifdef ADF5610_SEQ_READBACK_EN
      acc   <= acc_next;
`endif
    end
  end

  // bus strobes decode straight from state so reset removes them without a clock
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE) || accept;
  assign done        = (state == DONE);
  assign err         = err_q;
  assign spi_select  = (op_wr || op_rd) && !last;
  assign spi_write_n = !(op_wr && !last);
  assign spi_read_n  = !(op_rd && !last);
  assign spi_addr    = op_addr;
  assign spi_wdata   = op_wdata;
`ifdef ADF5610_SEQ_READBACK_EN
  assign rsp_data    = acc;
`else
  assign rsp_data    = '0;
`endif

endmodule

// File: doc/adf5610_spi_seq.md
# adf5610_spi_seq

Hardware sequencer that programs the ADF5610 synthesizer through the 8-bit SPI master's Avalon register port, without CPU involvement. It accepts one register word per request and runs the full transfer. That transfer clears status, asserts slave select, pushes the bytes MSB-first, holds SS_n low for the whole word through SSO, and then releases it. It sits between the frequency-control logic and the SPI master, which is configured CPOL=1, CPHA=1, 8 data bits, one slave, and 80 MHz → 4 MHz.

## Interface
Parameters:
- WORD_BYTES, 3: bytes per ADF5610 word, legal range 1..4.
- TIMEOUT_CYCLES, 4096: maximum clk cycles spent in any single poll state before the transfer aborts.

Ports:
- clk  in  1  system clock, 80 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  request strobe.
- cmd_ready  out  1  high only in IDLE; a request is accepted when cmd_valid & cmd_ready.
- cmd_data  in  32  word to send; bits [WORD_BYTES*8-1:0] are used and the top byte is sent first.
- busy  out  1  high from the acceptance cycle until the DONE cycle inclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: timeout, or ROE seen (readback builds only).
- rsp_data  out  32  captured MISO bytes, right-aligned; valid with done.
- spi_select  out  1  SPI core chip-select.
- spi_addr  out  3  SPI core register address.
- spi_wdata  out  16  SPI core write data.
- spi_read_n  out  1  SPI core read strobe, active-low.
- spi_write_n  out  1  SPI core write strobe, active-low.
- spi_rdata  in  16  SPI core registered read data.

## Operation
- Bus write: spi_select=1 and spi_write_n=0 for exactly 2 cycles with addr/wdata stable, then 1 gap cycle with select=0 and write_n=1. Total 3 cycles.
- Bus read: spi_select=1 and spi_read_n=0 for 2 cycles. In the 3rd cycle strobes deassert, addr is held, and spi_rdata is captured. Total 3 cycles.
- SPI register addresses: 0 rxdata, 1 txdata, 2 status, 3 control, 5 slave-enable.
- Status bits: 5 TMT, 6 TRDY, 7 RRDY, 3 ROE.
- FSM states:
  - IDLE: on accept, latch cmd_data, clear rx accumulator, set byte counter = WORD_BYTES-1 → CLR_STAT.
  - CLR_STAT: write addr 2, data 0 → SET_SS.
  - SET_SS: write addr 5, data 0x0001 → SET_SSO.
  - SET_SSO: write addr 3, data 0x0400 (SSO=1) → POLL_TRDY.
  - POLL_TRDY: read addr 2 repeatedly until TRDY=1 → WR_TX.
  - WR_TX: write addr 1 with the current byte in bits [7:0] and bits [15:8] = 0.
    - With readback: → POLL_RRDY.
    - Without readback: if bytes remain, decrement the counter and go → POLL_TRDY; otherwise → POLL_TMT.
  - POLL_RRDY: read addr 2 until RRDY=1 → RD_RX.
  - RD_RX: read addr 0; accumulator = {acc[23:0], rdata[7:0]}. If bytes remain → POLL_TRDY (counter decremented); else → POLL_TMT.
  - POLL_TMT: read addr 2 until TMT=1; latch ROE → REL_SSO.
  - REL_SSO: write addr 3, data 0 → DONE.
  - DONE: done=1, rsp_data/err valid → IDLE.
- Timeout: a per-poll-state cycle counter resets on entry to the state. When it reaches TIMEOUT_CYCLES, set the err flag and go → REL_SSO. SS is always released.
- Bytes go out MSB-first: byte index WORD_BYTES-1 down to 0 of cmd_data.
- cmd_valid during busy is ignored (not queued). cmd_data is don't-care unless accepted.

## Timing
- Reset values: cmd_ready=1, busy=0, done=0, err=0, rsp_data=0, spi_select=0, spi_read_n=1, spi_write_n=1, spi_addr=0, spi_wdata=0, FSM=IDLE.
- The first bus write (CLR_STAT) starts the cycle after acceptance.
- Setup (CLR_STAT, SET_SS, SET_SSO) takes 9 cycles before the first poll.
- Each poll iteration takes 3 cycles; the decision uses the value captured in the 3rd cycle.
- One SPI byte lasts ≈180 clk (18 states × 10).
- The IDLE→DONE→IDLE turnaround lets the next accept occur the cycle after done.
- Asynchronous reset mid-transfer forces reset values immediately, so bus strobes drop the same instant. The SPI core shares reset_n, so SS_n returns high through the core reset.
- err and rsp_data hold their values until the next acceptance.

## Configuration
- ADF5610_SEQ_READBACK_EN defined:
  - POLL_RRDY and RD_RX are compiled in.
  - rsp_data carries the MISO bytes.
  - ROE=1 at POLL_TMT sets err.
- Undefined:
  - No rxdata reads are issued; rsp_data is constant 0.
  - ROE is ignored. Status is cleared in CLR_STAT at the start of every transfer.

## Test plan
- Reset: assert reset_n=0 → all outputs at their reset values; cmd_ready=1.
- Readback build, SPI core with MISO looped to MOSI, cmd_data=0x00123456 → MOSI bytes 0x12, 0x34, 0x56; SS_n low continuously across all 24 SCLK edges; done=1 for one cycle; rsp_data=0x00123456; err=0.
- cmd_valid held high with 0xAAAAAA and then 0x555555 → second word accepted exactly 1 cycle after the first done; no bus access overlaps between the two transfers.
- Stub core with status stuck at 0x0000 → abort after TIMEOUT_CYCLES in POLL_TRDY; last bus write is addr 3 data 0; done with err=1.
- reset_n pulsed low during the second byte → spi_write_n/spi_read_n = 1 and spi_select = 0 asynchronously; after release, 0x00ABCDEF transfers correctly.
- Build without ADF5610_SEQ_READBACK_EN, cmd_data=0x00FF00F0 → no accesses to addr 0; rsp_data=0; done after the TMT poll; err=0.
